// File: rtl/ob_pkg.sv
// rtl/ob_pkg.sv - shared order-book types for the count controller and its engine
//
// Purpose: table side select and the accumulated-quantity result type used by
// the market-table count engine and every path that consumes its result.
// Ports: none (package).

package ob_pkg;

    localparam int ACCUM_W = 32;

    typedef logic [ACCUM_W-1:0] accum_quantity_t;

    typedef enum logic [0:0] {
        SIDE_BID = 1'b0,
        SIDE_ASK = 1'b1
    } side_t;

endpackage

// File: rtl/ob_mk_cnt_ctrl_if.sv
// rtl/ob_mk_cnt_ctrl_if.sv - requester request/response channel bundle
//
// Purpose: groups the per-requester count request and response handshakes.
// Signals:
//   req_vld/req_side/req_rdy       request channel, one bit/entry per requester
//   rsp_vld/rsp_rdy                response channel, one-hot to the accepted requester
//   rsp_quantity/rsp_err           shared response payload
// Modports: master = requester side, slave = controller side.

interface ob_mk_cnt_ctrl_if
    import ob_pkg::*;
#(
    parameter int REQ_N = 4
);

    logic [REQ_N-1:0]  req_vld;
    side_t [REQ_N-1:0] req_side;
    logic [REQ_N-1:0]  req_rdy;
    logic [REQ_N-1:0]  rsp_vld;
    logic [REQ_N-1:0]  rsp_rdy;
    accum_quantity_t   rsp_quantity;
    logic              rsp_err;

    modport master (
        output req_vld,
        output req_side,
        output rsp_rdy,
        input  req_rdy,
        input  rsp_vld,
        input  rsp_quantity,
        input  rsp_err
    );

    modport slave (
        input  req_vld,
        input  req_side,
        input  rsp_rdy,
        output req_rdy,
        output rsp_vld,
        output rsp_quantity,
        output rsp_err
    );

endinterface

// File: rtl/libv_arb_rr.sv
// rtl/libv_arb_rr.sv - round-robin arbiter with internal priority pointer
//
// Purpose: grants the first active request at or after the pointer; the
// pointer moves to one past the winner whenever the grant is taken.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req          request vector
//   en           grant was consumed this cycle; advance the pointer
//   gnt          one-hot grant (combinational)
//   gnt_idx      index of the granted request

module libv_arb_rr #(
    parameter  int REQ_N = 4,
    localparam int IDX_W = $clog2(REQ_N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REQ_N-1:0] req,
    input  logic             en,
    output logic [REQ_N-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W-1:0] cand_idx;
    logic             found;

    // Scan REQ_N positions starting at the pointer; the first hit wins.
    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        found    = 1'b0;
        cand_idx = '0;
        for (int i = 0; i < REQ_N; i++) begin
            cand_idx = IDX_W'((int'(ptr_r) + i) % REQ_N);
            if (!found && req[cand_idx]) begin
                found         = 1'b1;
                gnt[cand_idx] = 1'b1;
                gnt_idx       = cand_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (en) begin
            ptr_r <= (gnt_idx == IDX_W'(REQ_N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/ob_mk_cnt_ctrl.sv
// rtl/ob_mk_cnt_ctrl.sv - shares one market-table count engine among REQ_N requesters
//
// Purpose: round-robin arbitration of count requests, table lock handshake,
// one-cycle engine command, busy wait with watchdog, and a valid/ready
// response back to the winning requester.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   rq               requester channel (slave side of ob_mk_cnt_ctrl_if)
//   cnt_cmd_vld      one-cycle start command to the engine
//   cnt_side_r       table select for the engine, held ISSUE through RESP
//   cnt_busy_w       engine busy (falls in the cycle the result is valid)
//   cnt_quantity_w   engine result
//   tbl_lock_r       freezes table update logic
//   tbl_upd_pend     table update still in flight
//   busy             controller not idle
//   err_timeout_r    sticky watchdog expiry flag

module ob_mk_cnt_ctrl
    import ob_pkg::*;
#(
    parameter int REQ_N       = 4,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ob_mk_cnt_ctrl_if.slave         rq,
    output logic                    cnt_cmd_vld,
    output side_t                   cnt_side_r,
    input  logic                    cnt_busy_w,
    input  accum_quantity_t         cnt_quantity_w,
    output logic                    tbl_lock_r,
    input  logic                    tbl_upd_pend,
    output logic                    busy,
    output logic                    err_timeout_r
);

    localparam int IDX_W = $clog2(REQ_N);
    localparam int WD_W  = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    // IDLE is the all-zero encoding so busy is simply "state non-zero".
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOCK  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    state_t           state_r;
    state_t           state_nx;
    logic [IDX_W-1:0] idx_r;
    logic [WD_W-1:0]  wdog_r;
    accum_quantity_t  rsp_quantity_r;
    logic             rsp_err_r;

    logic [REQ_N-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             idle;
    logic             accept;
    logic             cap_ok;
    logic             cap_to;

    assign idle   = (state_r == ST_IDLE);
    assign accept = idle && (|gnt);

    libv_arb_rr #(
        .REQ_N (REQ_N)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (rq.req_vld),
        .en      (accept),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        state_nx = state_r;
        cap_ok   = 1'b0;
        cap_to   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept) begin
                    state_nx = ST_LOCK;
                end
            end
            ST_LOCK: begin
                // The lock is already visible for this cycle; an update that
                // was mid-flight keeps us here until it lands.
                if (!tbl_upd_pend) begin
                    state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (!cnt_busy_w) begin
                    cap_ok   = 1'b1;
                    state_nx = ST_RESP;
                end else if (wdog_r == WD_LAST) begin
                    cap_to   = 1'b1;
                    state_nx = ST_RESP;
                end
            end
            ST_RESP: begin
                // After a timeout the engine may still be running; it must
                // drain before a new command can be issued.
                if (rq.rsp_rdy[idx_r] && !cnt_busy_w) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r      <= '0;
            cnt_side_r <= SIDE_BID;
        end else if (accept) begin
            idx_r      <= gnt_idx;
            cnt_side_r <= rq.req_side[gnt_idx];
        end
    end

    // Watchdog saturates at its last value rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_r <= '0;
        end else if (state_r == ST_ISSUE) begin
            wdog_r <= '0;
        end else if (state_r == ST_WAIT && wdog_r != WD_LAST) begin
            wdog_r <= wdog_r + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_quantity_r <= '0;
            rsp_err_r      <= 1'b0;
            err_timeout_r  <= 1'b0;
        end else if (cap_ok) begin
            rsp_quantity_r <= cnt_quantity_w;
            rsp_err_r      <= 1'b0;
        end else if (cap_to) begin
            rsp_quantity_r <= '0;
            rsp_err_r      <= 1'b1;
            err_timeout_r  <= 1'b1;
        end
    end

    assign rq.req_rdy      = idle ? gnt : '0;
    assign rq.rsp_vld      = (state_r == ST_RESP) ? (REQ_N'(1) << idx_r) : '0;
    assign rq.rsp_quantity = rsp_quantity_r;
    assign rq.rsp_err      = rsp_err_r;

    assign cnt_cmd_vld = (state_r == ST_ISSUE);
    assign busy        = (state_r != ST_IDLE);

    // Lock covers LOCK..WAIT; in RESP it is held only while a timed-out
    // engine is still busy, so table updates cannot race a late engine.
    assign tbl_lock_r = (state_r == ST_LOCK) || (state_r == ST_ISSUE) ||
                        (state_r == ST_WAIT) ||
                        ((state_r == ST_RESP) && rsp_err_r && cnt_busy_w);

endmodule
